fpmul_issue_ctrl: RTL

- Shares the 2-stage FP multiplier (fpmul_r4) between NUM_REQ requesters, e.g. the FMUL issue path and the FMA front end.
- Drives the multiplier's operand inputs, en and clear[1:0].
- Shadows the multiplier's two pipeline stages with valid/tag/requester-id registers, so results return with identity and handshake.
- Handles downstream back-pressure and pipeline flush.

---
 rtl/riscv_types_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/fpmul_issue_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/riscv_types_pkg.sv
// Types and constants shared by the FP execution units.
package riscv_types;

  localparam int FPMUL_LATENCY = 2;
  localparam int FPMUL_TAG_W   = 4;

  typedef struct packed {
    logic [31:0]            a;
    logic [31:0]            b;
    logic [2:0]             rm;
    logic [FPMUL_TAG_W-1:0] tag;
  } fpmul_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot grant. The pointer moves past the winner
// only when a grant is actually issued (adv_i=1 and some request present).
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_s;
  logic          found_s;
  int            sum_s;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    ptr_d    = ptr_q;
    found_s  = 1'b0;
    idx_s    = '0;
    sum_s    = 0;
    for (int k = 0; k < N; k++) begin
      sum_s = int'(ptr_q) + k;
      if (sum_s >= N) begin
        sum_s = sum_s - N;
      end
      idx_s = IW'(sum_s);
      if (adv_i && !found_s && req_i[idx_s]) begin
        found_s       = 1'b1;
        gnt_o[idx_s]  = 1'b1;
        gnt_id_o      = idx_s;
        ptr_d         = (idx_s == IW'(N - 1)) ? '0 : idx_s + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fpmul_issue_ctrl.sv
// Issue controller for the shared 2-stage FP multiplier: arbitrates requesters,
// shadows the multiplier pipeline with valid/tag/id, handles stall and flush.
module fpmul_issue_ctrl
  import riscv_types::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int TAG_W       = FPMUL_TAG_W,
  parameter  int STALL_CNT_W = 16,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*32-1:0]    req_a_i,
  input  logic [NUM_REQ*32-1:0]    req_b_i,
  input  logic [NUM_REQ*3-1:0]     req_rm_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  output logic                     mul_en_o,
  output logic [1:0]               mul_clear_o,
  output logic [31:0]              mul_a_o,
  output logic [31:0]              mul_b_o,
  output logic [2:0]               mul_rm_o,
  input  logic                     flush_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [TAG_W-1:0]         res_tag_o,
  output logic [ID_W-1:0]          res_id_o,
  output logic                     busy_o,
  output logic [STALL_CNT_W-1:0]   stall_cnt_o
);

  logic               v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0]   tag1_q, tag1_d, tag2_q, tag2_d;
  logic [ID_W-1:0]    id1_q, id1_d, id2_q, id2_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic               kill_s, adv_s, any_gnt_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_id_s;
  fpmul_req_t         sel_s;

  // Reset is folded in with flush so the multiplier sees a clean clear while rst is held.
  assign kill_s    = rst | flush_i;
  assign adv_s     = !kill_s && (!v2_q || res_ready_i);
  assign any_gnt_s = |gnt_s;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_valid_i),
    .adv_i    (adv_s),
    .gnt_o    (gnt_s),
    .gnt_id_o (gnt_id_s)
  );

  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        sel_s.a   = req_a_i[32*i +: 32];
        sel_s.b   = req_b_i[32*i +: 32];
        sel_s.rm  = req_rm_i[3*i +: 3];
        sel_s.tag = FPMUL_TAG_W'(req_tag_i[TAG_W*i +: TAG_W]);
      end
    end
  end

  always_comb begin
    v1_d    = v1_q;
    v2_d    = v2_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    id1_d   = id1_q;
    id2_d   = id2_q;
    stall_d = stall_q;
    if (flush_i) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else if (adv_s) begin
      v1_d   = any_gnt_s;
      tag1_d = TAG_W'(sel_s.tag);
      id1_d  = gnt_id_s;
      v2_d   = v1_q;
      tag2_d = tag1_q;
      id2_d  = id1_q;
    end else begin
      v1_d = v1_q;
    end
    // Saturating count of back-pressured result cycles.
    if (v2_q && !res_ready_i && !flush_i && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      id1_q   <= '0;
      id2_q   <= '0;
      stall_q <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      id1_q   <= id1_d;
      id2_q   <= id2_d;
      stall_q <= stall_d;
    end
  end

  assign req_ready_o = gnt_s;
  assign mul_en_o    = adv_s;
  assign mul_clear_o = kill_s ? 2'b11 : {adv_s && !any_gnt_s, 1'b0};
  assign mul_a_o     = sel_s.a;
  assign mul_b_o     = sel_s.b;
  assign mul_rm_o    = sel_s.rm;
  assign res_valid_o = v2_q && !kill_s;
  assign res_tag_o   = tag2_q;
  assign res_id_o    = id2_q;
  assign busy_o      = v1_q | v2_q;
  assign stall_cnt_o = stall_q;

endmodule
